// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its initiator-side sequencer.
// Holds the opcode and sequencer state encodings, the flag bit positions
// used by both sides, and the opcode to one-hot strobe decode.
package alu_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CNT_W   = 4;

    // Flag bit positions inside fo / flags
    localparam int unsigned FLAG_C  = 0;
    localparam int unsigned FLAG_Z  = 1;
    localparam int unsigned FLAG_N  = 2;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_NOT = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_INV = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_EXEC = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // One field per ALU op strobe; bit position equals the opcode value
    typedef struct packed {
        logic shr;
        logic shl;
        logic op_not;
        logic op_or;
        logic op_and;
        logic sub;
        logic add;
    } strobe_t;

    // Opcode to one-hot strobe set; OP_INV yields no strobe at all
    function automatic strobe_t op_decode(input opcode_t op);
        strobe_t s;
        s = '0;
        case (op)
            OP_ADD:  s.add    = 1'b1;
            OP_SUB:  s.sub    = 1'b1;
            OP_AND:  s.op_and = 1'b1;
            OP_OR:   s.op_or  = 1'b1;
            OP_NOT:  s.op_not = 1'b1;
            OP_SHL:  s.shl    = 1'b1;
            OP_SHR:  s.shr    = 1'b1;
            default: s        = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_ctrl.sv
// Initiator-side sequencer for the 8-bit alu block.
// Takes one operation request over a start/done handshake, walks the ALU
// through LOAD -> EXEC -> OUT and captures the result and flags.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   start, opcode            request strobe and operation select
//   src_a, src_b, use_carry  operands and carry-chaining select
//   busy, done, err          handshake status (done is a one-cycle pulse)
//   result, flags            captured ALU result and flags
//   a, b, wa, wb, fi         ALU operand buses, write enables, flags-in
//   alu_add .. alu_shr       one-hot ALU op strobes
//   oe                       ALU output enable
//   d, fo                    ALU result and flags-out
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned FLAG_C      = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic [7:0] src_a,
    input  logic [7:0] src_b,
    input  logic       use_carry,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] result,
    output logic [7:0] flags,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic       wa,
    output logic       wb,
    output logic [7:0] fi,
    output logic       alu_add,
    output logic       alu_sub,
    output logic       alu_and,
    output logic       alu_or,
    output logic       alu_not,
    output logic       alu_shl,
    output logic       alu_shr,
    output logic       oe,
    input  logic [7:0] d,
    input  logic [7:0] fo
);

    state_t             state;
    opcode_t            op_q;
    logic [CNT_W-1:0]   cnt;
    strobe_t            strobe_q;

    // Strobe outputs come straight from the strobe register
    assign alu_add = strobe_q.add;
    assign alu_sub = strobe_q.sub;
    assign alu_and = strobe_q.op_and;
    assign alu_or  = strobe_q.op_or;
    assign alu_not = strobe_q.op_not;
    assign alu_shl = strobe_q.shl;
    assign alu_shr = strobe_q.shr;

    // Sequencer: every output is set on the edge that enters the state it belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= OP_ADD;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
            flags    <= '0;
            a        <= '0;
            b        <= '0;
            wa       <= 1'b0;
            wb       <= 1'b0;
            fi       <= '0;
            strobe_q <= '0;
            oe       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                // DONE accepts a new request exactly like IDLE, so ops can run back to back
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    if (start) begin
                        op_q <= opcode_t'(opcode);
                        if (opcode_t'(opcode) == OP_INV) begin
                            // Invalid op never touches the ALU; result/flags keep their values
                            state <= ST_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                            busy  <= 1'b1;
                            err   <= 1'b0;
                            a     <= src_a;
                            b     <= src_b;
                            wa    <= 1'b1;
                            wb    <= 1'b1;
                            // Carry comes from the flags register as of this edge, so a
                            // back-to-back accept sees the carry captured on entering DONE
                            fi    <= use_carry ? (8'(flags[FLAG_C]) << FLAG_C) : 8'h00;
                        end
                    end
                end

                ST_LOAD: begin
                    state    <= ST_EXEC;
                    wa       <= 1'b0;
                    wb       <= 1'b0;
                    strobe_q <= op_decode(op_q);
                    cnt      <= CNT_W'(EXEC_CYCLES - 1);
                end

                // Hold the strobe for EXEC_CYCLES cycles to let the ALU settle
                ST_EXEC: begin
                    if (cnt == '0) begin
                        state <= ST_OUT;
                        oe    <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_OUT: begin
                    state    <= ST_DONE;
                    result   <= d;
                    flags    <= fo;
                    strobe_q <= '0;
                    oe       <= 1'b0;
                    fi       <= '0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end

                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    wa       <= 1'b0;
                    wb       <= 1'b0;
                    fi       <= '0;
                    strobe_q <= '0;
                    oe       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: two sequencers (EXEC_CYCLES 1 and 3), each
// driving a small behavioural ALU (operand registers, one-hot op, oe-gated outputs).
module tb_alu_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start1, start3;
    logic [2:0] opcode;
    logic [7:0] src_a, src_b;
    logic       use_carry;

    logic       busy1, done1, err1, wa1, wb1, oe1;
    logic       add1, sub1, and1, or1, not1, shl1, shr1;
    logic [7:0] result1, flags1, a1, b1, fi1, d1, fo1;

    logic       busy3, done3, err3, wa3, wb3, oe3;
    logic       add3, sub3, and3, or3, not3, shl3, shr3;
    logic [7:0] result3, flags3, a3, b3, fi3, d3, fo3;

    alu_ctrl #(.EXEC_CYCLES(1), .FLAG_C(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .opcode(opcode),
        .src_a(src_a), .src_b(src_b), .use_carry(use_carry),
        .busy(busy1), .done(done1), .err(err1), .result(result1), .flags(flags1),
        .a(a1), .b(b1), .wa(wa1), .wb(wb1), .fi(fi1),
        .alu_add(add1), .alu_sub(sub1), .alu_and(and1), .alu_or(or1),
        .alu_not(not1), .alu_shl(shl1), .alu_shr(shr1),
        .oe(oe1), .d(d1), .fo(fo1)
    );

    alu_ctrl #(.EXEC_CYCLES(3), .FLAG_C(0)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .opcode(opcode),
        .src_a(src_a), .src_b(src_b), .use_carry(use_carry),
        .busy(busy3), .done(done3), .err(err3), .result(result3), .flags(flags3),
        .a(a3), .b(b3), .wa(wa3), .wb(wb3), .fi(fi3),
        .alu_add(add3), .alu_sub(sub3), .alu_and(and3), .alu_or(or3),
        .alu_not(not3), .alu_shl(shl3), .alu_shr(shr3),
        .oe(oe3), .d(d3), .fo(fo3)
    );

    // Behavioural ALU: operand registers plus oe-gated combinational result
    logic [7:0] ra1, rb1, ra3, rb3;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ra1 <= '0; rb1 <= '0; ra3 <= '0; rb3 <= '0;
        end else begin
            if (wa1) ra1 <= a1;
            if (wb1) rb1 <= b1;
            if (wa3) ra3 <= a3;
            if (wb3) rb3 <= b3;
        end
    end

    function automatic logic [15:0] alu_model(input logic [6:0] st, input logic en,
                                              input logic [7:0] x, input logic [7:0] y,
                                              input logic [7:0] ci);
        logic [8:0] w;
        logic [7:0] f;
        case (st)
            7'b0000001: w = {1'b0, x} + {1'b0, y} + 9'(ci[FLAG_C]);
            7'b0000010: w = {1'b0, x} - {1'b0, y} - 9'(ci[FLAG_C]);
            7'b0000100: w = {1'b0, x & y};
            7'b0001000: w = {1'b0, x | y};
            7'b0010000: w = {1'b0, ~x};
            7'b0100000: w = {1'b0, x << y[2:0]};
            7'b1000000: w = {1'b0, x >> y[2:0]};
            default:    w = '0;
        endcase
        f = '0;
        f[FLAG_C] = w[8];
        f[FLAG_Z] = (w[7:0] == 8'h00);
        f[FLAG_N] = w[7];
        return en ? {f, w[7:0]} : 16'h0000;
    endfunction

    assign {fo1, d1} = alu_model({shr1, shl1, not1, or1, and1, sub1, add1}, oe1, ra1, rb1, fi1);
    assign {fo3, d3} = alu_model({shr3, shl3, not3, or3, and3, sub3, add3}, oe3, ra3, rb3, fi3);

    // Observed outputs of each sequencer, bundled for the step tasks
    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic [7:0] result;
        logic [7:0] flags;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] fi;
        logic       wa;
        logic       wb;
        logic       oe;
        logic [6:0] st;
    } obs_t;

    obs_t o1, o3;
    assign o1 = {busy1, done1, err1, result1, flags1, a1, b1, fi1, wa1, wb1, oe1,
                 {shr1, shl1, not1, or1, and1, sub1, add1}};
    assign o3 = {busy3, done3, err3, result3, flags3, a3, b3, fi3, wa3, wb3, oe3,
                 {shr3, shl3, not3, or3, and3, sub3, add3}};

    int dcnt1 = 0;
    always @(posedge clk) if (done1) dcnt1 <= dcnt1 + 1;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_chk++;
        assert (observed === expected) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 3) start3 = v;
        else            start1 = v;
    endtask

    function automatic obs_t obs(input int which);
        return (which == 3) ? o3 : o1;
    endfunction

    // Issue one request, then follow it sample by sample until done (bounded)
    task automatic run_op(input int which, input logic [2:0] op, input logic [7:0] sa,
                          input logic [7:0] sb, input logic uc, input bit mid,
                          output int lat, output int n_wa, output int n_str,
                          output int n_oe, output int n_bad,
                          output logic [7:0] fi_ld, output logic busy_ld);
        obs_t       o;
        logic [6:0] exp_oh;
        logic [6:0] one;
        one    = 7'd1;
        exp_oh = (op == 3'd7) ? 7'd0 : (one << op);
        lat = -1; n_wa = 0; n_str = 0; n_oe = 0; n_bad = 0;
        fi_ld = '0; busy_ld = 1'b0;
        opcode = op; src_a = sa; src_b = sb; use_carry = uc;
        set_start(which, 1'b1);
        tick();
        set_start(which, 1'b0);
        for (int n = 0; n < 40; n++) begin
            o = obs(which);
            if (n == 0) begin
                fi_ld   = o.fi;
                busy_ld = o.busy;
            end
            if (o.wa || o.wb) n_wa++;
            if (o.st != 7'd0) n_str++;
            if (o.oe) n_oe++;
            if ((o.st != 7'd0 && o.st != exp_oh) || (o.oe && o.st == 7'd0)) n_bad++;
            if (o.done) begin
                lat = n;
                break;
            end
            if (mid && n == 1) set_start(which, 1'b1);
            tick();
            set_start(which, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat, n_wa, n_str, n_oe, n_bad, dsnap;
        logic [7:0] fi_ld;
        logic       busy_ld;

        rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
        opcode = '0; src_a = '0; src_b = '0; use_carry = 1'b0;
        #22;
        chk("rst_busy",   32'(o1.busy),   32'd0);
        chk("rst_done",   32'(o1.done),   32'd0);
        chk("rst_err",    32'(o1.err),    32'd0);
        chk("rst_result", 32'(o1.result), 32'd0);
        chk("rst_ctrl",   32'({o1.a, o1.b, o1.fi, o1.wa, o1.wb, o1.oe, o1.st}), 32'd0);
        chk("rst_dut3",   32'({o3.busy, o3.done, o3.st, o3.oe}), 32'd0);
        rst = 1'b0;
        tick();
        tick();

        // Basic add 100 + 1
        run_op(1, 3'd0, 8'd100, 8'd1, 1'b0, 1'b0, lat, n_wa, n_str, n_oe, n_bad, fi_ld, busy_ld);
        chk("add_lat",    32'(lat),        32'd3);
        chk("add_result", 32'(o1.result),  32'd101);
        chk("add_carry",  32'(o1.flags[0]), 32'd0);
        chk("add_err",    32'(o1.err),     32'd0);
        chk("add_busy",   32'(busy_ld),    32'd1);
        chk("add_wa",     32'(n_wa),       32'd1);
        chk("add_str",    32'(n_str),      32'd2);
        chk("add_oe",     32'(n_oe),       32'd1);
        chk("add_onehot", 32'(n_bad),      32'd0);
        chk("add_fi",     32'(fi_ld),      32'd0);
        tick();
        chk("done_pulse", 32'(o1.done),    32'd0);
        tick();

        // Carry chain: 200 + 100, then back-to-back 1 + 1 + carry
        run_op(1, 3'd0, 8'd200, 8'd100, 1'b0, 1'b0, lat, n_wa, n_str, n_oe, n_bad, fi_ld, busy_ld);
        chk("cc1_result", 32'(o1.result), 32'd44);
        chk("cc1_flags",  32'(o1.flags),  32'h01);
        run_op(1, 3'd0, 8'd1, 8'd1, 1'b1, 1'b0, lat, n_wa, n_str, n_oe, n_bad, fi_ld, busy_ld);
        chk("cc2_fi",     32'(fi_ld),     32'h01);
        chk("cc2_lat",    32'(lat),       32'd3);
        chk("cc2_result", 32'(o1.result), 32'd3);
        chk("cc2_flags",  32'(o1.flags),  32'h00);
        tick();

        // Shifts and unary not
        run_op(1, 3'd5, 8'd43, 8'd1, 1'b0, 1'b0, lat, n_wa, n_str, n_oe, n_bad, fi_ld, busy_ld);
        chk("shl_result", 32'(o1.result), 32'd86);
        chk("shl_onehot", 32'(n_bad),     32'd0);
        run_op(1, 3'd6, 8'd100, 8'd2, 1'b0, 1'b0, lat, n_wa, n_str, n_oe, n_bad, fi_ld, busy_ld);
        chk("shr_result", 32'(o1.result), 32'd25);
        chk("shr_onehot", 32'(n_bad),     32'd0);
        run_op(1, 3'd4, 8'h0F, 8'hAA, 1'b0, 1'b0, lat, n_wa, n_str, n_oe, n_bad, fi_ld, busy_ld);
        chk("not_result", 32'(o1.result), 32'hF0);
        chk("not_onehot", 32'(n_bad + n_str), 32'd2);
        tick();

        // Invalid opcode
        run_op(1, 3'd7, 8'd9, 8'd9, 1'b0, 1'b0, lat, n_wa, n_str, n_oe, n_bad, fi_ld, busy_ld);
        chk("inv_lat",    32'(lat),        32'd0);
        chk("inv_err",    32'(o1.err),     32'd1);
        chk("inv_result", 32'(o1.result),  32'hF0);
        chk("inv_busy",   32'(busy_ld),    32'd0);
        chk("inv_act",    32'(n_wa + n_str + n_oe), 32'd0);
        tick();
        chk("inv_after",  32'({o1.err, o1.done, o1.oe, o1.st}), 32'h200);

        // start pulsed during EXEC is ignored
        dsnap = dcnt1;
        run_op(1, 3'd0, 8'd10, 8'd20, 1'b0, 1'b1, lat, n_wa, n_str, n_oe, n_bad, fi_ld, busy_ld);
        chk("mid_lat",    32'(lat),       32'd3);
        chk("mid_result", 32'(o1.result), 32'd30);
        chk("mid_err",    32'(o1.err),    32'd0);
        repeat (5) tick();
        chk("mid_ndone",  32'(dcnt1 - dsnap), 32'd1);

        // Reset in the middle of an op
        opcode = 3'd1; src_a = 8'd50; src_b = 8'd3; use_carry = 1'b0;
        set_start(1, 1'b1);
        tick();
        set_start(1, 1'b0);
        tick();
        chk("pre_rst_sub", 32'(o1.st), 32'h02);
        dsnap = dcnt1;
        #1 rst = 1'b1;
        #1;
        chk("arst_busy",   32'(o1.busy),   32'd0);
        chk("arst_ctrl",   32'({o1.st, o1.oe, o1.wa, o1.wb}), 32'd0);
        chk("arst_a",      32'(o1.a),      32'd0);
        chk("arst_result", 32'(o1.result), 32'd0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("arst_nodone", 32'(dcnt1 - dsnap), 32'd0);
        run_op(1, 3'd1, 8'd100, 8'd1, 1'b0, 1'b0, lat, n_wa, n_str, n_oe, n_bad, fi_ld, busy_ld);
        chk("sub_lat",    32'(lat),       32'd3);
        chk("sub_result", 32'(o1.result), 32'd99);

        // EXEC_CYCLES = 3 instance
        run_op(3, 3'd0, 8'd5, 8'd6, 1'b0, 1'b0, lat, n_wa, n_str, n_oe, n_bad, fi_ld, busy_ld);
        chk("e3_lat",    32'(lat),       32'd5);
        chk("e3_str",    32'(n_str),     32'd4);
        chk("e3_oe",     32'(n_oe),      32'd1);
        chk("e3_result", 32'(o3.result), 32'd11);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
- Initiator-side sequencer for the 8-bit `alu` block.
- Accepts one operation request (opcode plus two operands) over a start/done handshake.
- Drives the ALU operand loads (a/b/wa/wb), one-hot op strobes, carry-in (fi) and output enable (oe) in a fixed multi-cycle sequence.
- Captures the ALU result bus (d) and flags (fo) into registers for the CPU datapath.

Parameters:
EXEC_CYCLES, 1, cycles the op strobe is held before oe is raised (ALU settle time); legal range 1..15
FLAG_C, 0, bit index of carry within fo/flags

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request strobe; sampled only in IDLE or DONE
opcode  input  3  0 add, 1 sub, 2 and, 3 or, 4 not, 5 shl, 6 shr, 7 invalid
src_a  input  8  operand A
src_b  input  8  operand B (shift amount for shl/shr, ignored by not)
use_carry  input  1  1: fi carries the previous op's captured carry; 0: fi = 0
busy  output  1  high from accepted start until DONE
done  output  1  one-cycle pulse; result/flags/err valid
err  output  1  set with done when opcode was 7; cleared on next accept
result  output  8  captured d
flags  output  8  captured fo
a, b  output  8  ALU operand buses
wa, wb  output  1  ALU operand register write enables
fi  output  8  ALU flags-in
alu_add, alu_sub, alu_and, alu_or, alu_not, alu_shl, alu_shr  output  1  one-hot op strobes
oe  output  1  ALU output enable
d  input  8  ALU result
fo  input  8  ALU flags-out

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - All outputs go to 0, including result, flags, err, busy and done.
  - An in-flight op is abandoned and no done is produced.
- States: IDLE -> LOAD -> EXEC -> OUT -> DONE -> IDLE.
- IDLE:
  - All ALU controls are low.
  - start=1 latches opcode, src_a, src_b and use_carry, clears err, sets busy and goes to LOAD.
  - opcode=7 goes directly to DONE with err=1; result and flags are unchanged.
- LOAD (1 cycle):
  - a=src_a, b=src_b, wa=wb=1.
  - fi = use_carry ? ({7'b0, flags[FLAG_C]} shifted to FLAG_C) : 0.
  - fi is held at this value until DONE.
- EXEC (EXEC_CYCLES cycles):
  - wa=wb=0; the selected strobe is high and all others are low.
  - A 4-bit counter counts down to 0, then the block goes to OUT.
- OUT (1 cycle):
  - The strobe is still high and oe=1.
  - On the closing edge, result<=d and flags<=fo.
- DONE (1 cycle):
  - done=1, busy=0, all strobes/oe/wa/wb low.
  - start=1 here is accepted exactly as in IDLE (back-to-back ops, no bubble).
- Latency:
  - done is high in cycle k+3+EXEC_CYCLES after the start edge k.
  - For opcode 7, done is high in cycle k+1.
- start while busy (LOAD/EXEC/OUT) is ignored and not queued.
- Strobes are strictly one-hot, and none are high outside EXEC/OUT.
- oe is high only in OUT.
- a/b hold their last driven values after LOAD.
- Carry chaining uses the flags register as of the accept edge, so a back-to-back accept in DONE sees the just-captured carry.

Decomposition:
- Package alu_pkg holds:
  - opcode enum (OP_ADD..OP_SHR, OP_INV = 7);
  - state enum;
  - FLAG_C/FLAG_Z/FLAG_N bit-index constants shared with `alu`.
- No sub-module. The opcode-to-one-hot strobe decode is a function in alu_pkg.

Test Plan:
- The bench instantiates alu_ctrl connected to the real `alu`, with EXEC_CYCLES=1.
- Basic add: opcode 0, src_a=100, src_b=1, use_carry=0 -> done at cycle k+4; result=101, carry=0, err=0; wa=wb=1 only in LOAD, alu_add high exactly 2 cycles, oe high 1 cycle.
- Carry chain: add 200+100 -> result=44, carry=1; back-to-back start in DONE with add 1+1, use_carry=1 -> fi[FLAG_C]=1, result=3.
- Shifts/unary:
  - shl with a=43, b=1 -> result 86.
  - shr with a=100, b=2 -> result 25.
  - not with a=0x0F -> result 0xF0.
  - Check one-hot strobes on every op.
- Invalid/ignored:
  - opcode 7 -> done at k+1 with err=1, result unchanged, no strobe or oe activity.
  - start pulsed during EXEC -> ignored; exactly one done.
- Reset mid-op: assert rst during EXEC -> all outputs 0 immediately (asynchronously, before next clk edge), no done; after release, a new sub 100-1 gives result=99.
- EXEC_CYCLES=3 build: add 5+6 -> strobe high 4 cycles, done at k+6, result=11.
